// File: rtl/wb_slave_regbank.sv
// Wishbone classic register bank: ID word, free-running counter, byte-writable
// scratch words, programmable wait states and error response for bad addresses.
module wb_slave_regbank #(
    parameter int          dw          = 32,
    parameter int          aw          = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5742_0001
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [dw-1:0] wb_dat_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o
);

    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [dw-1:0] wdat_q, wdat_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [dw-1:0] scratch_q [2:NUM_REGS-1];
    logic [dw-1:0] scratch_d [2:NUM_REGS-1];

    logic          req;
    logic          bad_adr;
    logic          commit;
    logic [dw-1:0] rdata;

    assign req     = wb_cyc_i & wb_stb_i;
    assign bad_adr = (wb_adr_i[aw-1:2] >= (aw-2)'(NUM_REGS))
                   | (wb_adr_i[1:0] != 2'b00);
    assign commit  = (state_q == S_RESP) & we_q & ~err_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = wb_adr_i[2 +: IW];
                    err_d   = bad_adr;
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    wdat_d  = wb_dat_i;
                    wcnt_d  = 4'(WAIT_STATES - 1);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Master abandoning the cycle drops the request silently
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_DONE;
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + 32'd1;
        scratch_d = scratch_q;
        if (commit) begin
            if (int'(idx_q) == 1) begin
                if (|sel_q) begin
                    cnt_d = 32'd0;
                end
            end else if (int'(idx_q) >= 2) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_q[b]) begin
                        scratch_d[idx_q][8*b +: 8] = wdat_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(idx_q) == 0) begin
            rdata = ID_VALUE;
        end else if (int'(idx_q) == 1) begin
            rdata = cnt_q;
        end else if (int'(idx_q) < NUM_REGS) begin
            rdata = scratch_q[idx_q];
        end
    end

    assign wb_ack_o = (state_q == S_RESP) & ~err_q;
    assign wb_err_o = (state_q == S_RESP) & err_q;
    assign wb_dat_o = ((state_q == S_RESP) & ~err_q & ~we_q) ? rdata : '0;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            for (int i = 2; i < NUM_REGS; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
        end
    end

endmodule

// File: tb/tb_wb_slave_regbank.sv
// Directed bench for wb_slave_regbank: one instance with no wait states,
// one with three, sharing the bus signals but gated by cyc.
module tb_wb_slave_regbank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we, use3;
    logic [31:0] adr, dat;
    logic [3:0]  sel;

    logic [31:0] dat0, dat3, rdat;
    logic        ack0, err0, ack3, err3, ack, err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_slave_regbank #(.WAIT_STATES(0)) u_dut0 (
        .wb_clk   (clk),
        .wb_rst   (rst_n),
        .wb_cyc_i (cyc & ~use3),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (dat),
        .wb_dat_o (dat0),
        .wb_ack_o (ack0),
        .wb_err_o (err0)
    );

    wb_slave_regbank #(.WAIT_STATES(3)) u_dut3 (
        .wb_clk   (clk),
        .wb_rst   (rst_n),
        .wb_cyc_i (cyc & use3),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (dat),
        .wb_dat_o (dat3),
        .wb_ack_o (ack3),
        .wb_err_o (err3)
    );

    assign ack  = use3 ? ack3 : ack0;
    assign err  = use3 ? err3 : err0;
    assign rdat = use3 ? dat3 : dat0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one access and wait (bounded) for ack/err; called #1 after an edge.
    task automatic run(input string tag, input logic w,
                       input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input int exp_lat,
                       input logic exp_err, input logic [31:0] exp_dat);
        int          lat;
        logic        g_ack, g_err;
        logic [31:0] g_dat;
        lat   = -1;
        g_ack = 1'b0;
        g_err = 1'b0;
        g_dat = 32'hx;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack | err) begin
                lat   = k;
                g_ack = ack;
                g_err = err;
                g_dat = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " ack/err"}, {30'd0, g_ack, g_err}, {30'd0, ~exp_err, exp_err});
        if (!w) chk({tag, " data"}, g_dat, exp_dat);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n_ack;
        int first;
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; use3 = 1'b0;
        adr = '0; sel = '0; dat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack0", {31'd0, ack0}, 32'd0);
        chk("reset err0", {31'd0, err0}, 32'd0);
        chk("reset dat0", dat0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("id read", 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h5742_0001);
        chk("dat idle zero", rdat, 32'd0);
        run("id write", 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1, 1'b0, 32'h0);
        run("id reread", 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h5742_0001);

        run("wr 8 lanes", 1'b1, 32'h8, 4'b0101, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
        run("rd 8 lanes", 1'b0, 32'h8, 4'b0000, 32'h0, 1, 1'b0, 32'h00AD_00EF);
        run("wr 8 full", 1'b1, 32'h8, 4'hF, 32'h1234_5678, 1, 1'b0, 32'h0);
        run("rd 8 full", 1'b0, 32'h8, 4'hF, 32'h0, 1, 1'b0, 32'h1234_5678);
        run("wr 3c top", 1'b1, 32'h3C, 4'b1000, 32'hAB00_0000, 1, 1'b0, 32'h0);
        run("rd 3c", 1'b0, 32'h3C, 4'hF, 32'h0, 1, 1'b0, 32'hAB00_0000);

        run("rd 40 oob", 1'b0, 32'h40, 4'hF, 32'h0, 1, 1'b1, 32'h0);
        run("rd 9 misal", 1'b0, 32'h9, 4'hF, 32'h0, 1, 1'b1, 32'h0);
        run("wr a misal", 1'b1, 32'hA, 4'hF, 32'h0, 1, 1'b1, 32'h0);
        run("wr 40 oob", 1'b1, 32'h40, 4'hF, 32'h0, 1, 1'b1, 32'h0);
        run("rd 8 intact", 1'b0, 32'h8, 4'hF, 32'h0, 1, 1'b0, 32'h1234_5678);

        run("cnt clear", 1'b1, 32'h4, 4'hF, 32'hFFFF_FFFF, 1, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        run("cnt read", 1'b0, 32'h4, 4'hF, 32'h0, 1, 1'b0, 32'd4);

        use3 = 1'b1;
        run("ws3 id", 1'b0, 32'h0, 4'hF, 32'h0, 4, 1'b0, 32'h5742_0001);
        run("ws3 wr c", 1'b1, 32'hC, 4'hF, 32'h1111_2222, 4, 1'b0, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC;
        sel = 4'hF; dat = 32'h9999_9999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_ack = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack | err) n_ack++;
        end
        chk("abort no resp", n_ack, 0);
        run("ws3 rd c", 1'b0, 32'hC, 4'hF, 32'h0, 4, 1'b0, 32'h1111_2222);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        n_ack = 0;
        first = -1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                n_ack++;
                if (first < 0) first = k;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("held stb acks", n_ack, 1);
        chk("held stb lat", first, 4);
        repeat (2) @(posedge clk);
        #1;

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC;
        sel = 4'hF; dat = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst mid ack", {31'd0, ack3}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack | err) n_ack++;
        end
        chk("rst no resp", n_ack, 0);
        run("rst rd c", 1'b0, 32'hC, 4'hF, 32'h0, 4, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
